// File: rtl/motor_mon_pkg.sv
// Shared types and constants for the alternating-motor output monitor.
package motor_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_M1 = 2'd1,
    RUN_M2 = 2'd2
  } mon_state_t;

  localparam int unsigned FLT_OVERLAP = 0;
  localparam int unsigned FLT_OVERRUN = 1;
  localparam int unsigned FLT_EARLY   = 2;
  localparam int unsigned FLT_SEQ     = 3;
  localparam int unsigned FLT_W       = 4;
  localparam int unsigned ALT_CNT_W   = 16;

  // Increment that sticks at all-ones.
  function automatic logic [ALT_CNT_W-1:0] sat_inc_alt(input logic [ALT_CNT_W-1:0] v);
    return (&v) ? v : v + ALT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/motor_mon_dwell_cnt.sv
// Saturating dwell counter with live-mode limit/tolerance compares.
module motor_mon_dwell_cnt #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned T_NORMAL_S = 30,
  parameter int unsigned T_TEST_S   = 3,
  parameter int unsigned TOL_CYC    = CLK_HZ / 100,
  parameter int unsigned CNT_W      = $clog2(CLK_HZ * T_NORMAL_S + TOL_CYC + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic             clr,
  input  logic             test_mode,
  output logic [CNT_W-1:0] dwell,
  output logic             over_o,
  output logic             early_o
);

  localparam longint unsigned LIM_N = 64'(CLK_HZ) * 64'(T_NORMAL_S);
  localparam longint unsigned LIM_T = 64'(CLK_HZ) * 64'(T_TEST_S);
  localparam longint unsigned TOL   = 64'(TOL_CYC);

  localparam logic [CNT_W-1:0] OVR_N = CNT_W'(LIM_N + TOL);
  localparam logic [CNT_W-1:0] OVR_T = CNT_W'(LIM_T + TOL);
  // Early threshold clamps at zero when the tolerance exceeds the limit.
  localparam logic [CNT_W-1:0] ERL_N = CNT_W'((LIM_N > TOL) ? LIM_N - TOL : 64'd0);
  localparam logic [CNT_W-1:0] ERL_T = CNT_W'((LIM_T > TOL) ? LIM_T - TOL : 64'd0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dwell <= '0;
    end else if (load) begin
      dwell <= CNT_W'(1);
    end else if (inc && !(&dwell)) begin
      dwell <= dwell + CNT_W'(1);
    end
  end

  assign over_o  = dwell > (test_mode ? OVR_T : OVR_N);
  assign early_o = dwell < (test_mode ? ERL_T : ERL_N);

endmodule

// File: rtl/motor_alternation_monitor.sv
// Passive alternation-protocol checker for the two-motor controller outputs.
// Optional last-run dwell capture enabled by defining MOTOR_MON_DWELL_EN.
module motor_alternation_monitor
  import motor_mon_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned T_NORMAL_S = 30,
  parameter int unsigned T_TEST_S   = 3,
  parameter int unsigned TOL_CYC    = CLK_HZ / 100,
  parameter int unsigned CNT_W      = $clog2(CLK_HZ * T_NORMAL_S + TOL_CYC + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m1_on,
  input  logic                 m2_on,
  input  logic                 test_mode,
  input  logic                 clr_faults,
  output logic                 fault_overlap,
  output logic                 fault_overrun,
  output logic                 fault_early,
  output logic                 fault_seq,
  output logic                 fault_any,
  output logic [ALT_CNT_W-1:0] alt_count,
  output logic [CNT_W-1:0]     last_dwell
);

  mon_state_t         state, state_n;
  logic               load, inc, clr_dwell, handover, set_seq;
  logic               over, early, ovr_seen;
  logic [CNT_W-1:0]   dwell;
  logic [FLT_W-1:0]   flags, flags_n, set_vec;
  logic               set_early;

  motor_mon_dwell_cnt #(
    .CLK_HZ    (CLK_HZ),
    .T_NORMAL_S(T_NORMAL_S),
    .T_TEST_S  (T_TEST_S),
    .TOL_CYC   (TOL_CYC),
    .CNT_W     (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .inc      (inc),
    .clr      (clr_dwell),
    .test_mode(test_mode),
    .dwell    (dwell),
    .over_o   (over),
    .early_o  (early)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and counter commands; overlap falls through with everything frozen.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    inc       = 1'b0;
    clr_dwell = 1'b0;
    handover  = 1'b0;
    set_seq   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m1_on && !m2_on) begin
          state_n = RUN_M1;
          load    = 1'b1;
        end else if (!m1_on && m2_on) begin
          state_n = RUN_M2;
          load    = 1'b1;
          set_seq = 1'b1;
        end
      end
      RUN_M1: begin
        if (m1_on && !m2_on) begin
          inc = 1'b1;
        end else if (!m1_on && m2_on) begin
          state_n  = RUN_M2;
          load     = 1'b1;
          handover = 1'b1;
        end else if (!m1_on && !m2_on) begin
          state_n   = IDLE;
          clr_dwell = 1'b1;
        end
      end
      RUN_M2: begin
        if (m2_on && !m1_on) begin
          inc = 1'b1;
        end else if (!m2_on && m1_on) begin
          state_n  = RUN_M1;
          load     = 1'b1;
          handover = 1'b1;
        end else if (!m1_on && !m2_on) begin
          state_n   = IDLE;
          clr_dwell = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Fault detection for the current sample.
  always_comb begin
    set_vec              = '0;
    set_vec[FLT_OVERLAP] = m1_on && m2_on;
    set_vec[FLT_OVERRUN] = (state != IDLE) && over && !ovr_seen;
    set_vec[FLT_EARLY]   = handover && early && !ovr_seen;
    set_vec[FLT_SEQ]     = set_seq;
  end

  assign set_early = set_vec[FLT_EARLY];
  assign flags_n   = (flags & ~{FLT_W{clr_faults}}) | set_vec;

  // Overrun is reported once per run, independent of clr_faults.
  always_ff @(posedge clk) begin
    if (rst || load || clr_dwell) ovr_seen <= 1'b0;
    else if (set_vec[FLT_OVERRUN]) ovr_seen <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags     <= '0;
      fault_any <= 1'b0;
      alt_count <= '0;
    end else begin
      flags     <= flags_n;
      fault_any <= |flags_n;
      if (handover && !set_early) alt_count <= sat_inc_alt(alt_count);
    end
  end

  assign fault_overlap = flags[FLT_OVERLAP];
  assign fault_overrun = flags[FLT_OVERRUN];
  assign fault_early   = flags[FLT_EARLY];
  assign fault_seq     = flags[FLT_SEQ];

`ifdef MOTOR_MON_DWELL_EN
  logic run_exit;

  // load outside IDLE is a handover; clr_dwell only happens on a stop.
  assign run_exit = clr_dwell || (load && (state != IDLE));

  always_ff @(posedge clk) begin
    if (rst)           last_dwell <= '0;
    else if (run_exit) last_dwell <= dwell;
  end
`else
  logic dwell_unused;

  assign dwell_unused = ^dwell;
  assign last_dwell   = '0;
`endif

endmodule
